dmem_access_unit: RTL and testbench
===================================

# dmem_access_unit

Data-memory access sequencer between the datapath's memory-control signals (MemRead/MemWrite from the control unit) and a single-ported request/acknowledge data bus. It converts a load or store in the MEM stage into one bus transaction and stalls the pipeline until the bus acknowledges. Loads return a registered data word, and misaligned word accesses are rejected before reaching the bus.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 16, cycles spent in REQ without ack before abort (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_read  in  1  MemRead from control unit
- mem_write  in  1  MemWrite from control unit
- addr  in  ADDR_W  ALU-computed effective address
- wdata  in  DATA_W  store data (rs2)
- stall  out  1  hold PC and pipeline registers
- rdata  out  DATA_W  load result
- rdata_valid  out  1  one-cycle pulse; rdata holds the load result
- misalign_err  out  1  addr[1:0] != 0 on an access request
- timeout_err  out  1  bus timeout pulse (tied 0 without MEM_TIMEOUT_EN)
- bus_req  out  1  transaction request
- bus_we  out  1  1 = write, 0 = read
- bus_addr  out  ADDR_W  transaction address
- bus_wdata  out  DATA_W  write data
- bus_ack  in  1  transaction complete; sampled only while bus_req = 1
- bus_rdata  in  DATA_W  read data, valid in the ack cycle

Clock is clk. Reset is rst: asynchronous, active-high.

## Operation
- FSM states: IDLE, REQ, RESP.
- In IDLE, an access is `acc = mem_read | mem_write`.
- IDLE, acc, aligned:
  - Latch addr and wdata into bus_addr and bus_wdata.
  - Latch bus_we = mem_write. If mem_read and mem_write are both high, the write takes priority.
  - Go to REQ.
- IDLE, acc, misaligned:
  - misalign_err = 1 combinationally.
  - No stall, no bus activity, state stays IDLE.
- REQ:
  - bus_req = 1.
  - bus_addr, bus_we and bus_wdata are held stable.
  - On bus_ack: if !bus_we, rdata <= bus_rdata. Go to RESP.
- RESP, for exactly one cycle:
  - bus_req = 0.
  - rdata_valid = 1 for loads only.
  - Return to IDLE.
- rdata holds its value until the next load completes.
- stall, combinational:
  - 1 in IDLE when acc and aligned.
  - 1 throughout REQ.
  - 0 in RESP, so the instruction advances at the end of the RESP cycle.
  - Forced to 0 while rst = 1.
- Each instruction causes exactly one transaction.
- mem_read and mem_write changes during REQ are ignored.
- Reset values:
  - state = IDLE.
  - bus_req, bus_we, rdata_valid, timeout_err = 0.
  - bus_addr, bus_wdata, rdata = 0.
  - stall = 0, misalign_err = 0.
- Reset mid-transaction: bus_req drops immediately (asynchronously) and no rdata_valid is produced.

## Timing
- Cycle 0 (IDLE, request seen): stall = 1.
- Cycle 1 (REQ): bus_req = 1. The earliest bus_ack is in this cycle.
- Cycle 2 (RESP): stall = 0; rdata_valid = 1 for a load.
- Minimum access is 3 cycles with 2 stall cycles. Each wait cycle with bus_ack low adds 1.
- Back-to-back accesses: the next access is detected in the cycle after RESP. bus_req is low for at least 2 cycles between transactions.
- All registered outputs change on the rising edge of clk. stall and misalign_err are combinational from state and inputs.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A cycle counter runs in REQ and clears on entry to REQ.
  - After TIMEOUT_CYCLES consecutive cycles without ack, the transaction aborts: bus_req drops, the FSM goes to RESP, timeout_err = 1 for that RESP cycle, and rdata is unchanged with rdata_valid = 0.
  - An ack in the same cycle as the count expiring takes priority over the timeout.
- MEM_TIMEOUT_EN undefined: no counter is built, REQ waits for bus_ack indefinitely, and timeout_err is tied to 0.

## Test plan
- Load with ack in the first REQ cycle: mem_read = 1, addr = 0x100, bus_rdata = 0xDEADBEEF. Expect bus_req high for 1 cycle with bus_we = 0 and bus_addr = 0x100; stall high for 2 cycles; then rdata_valid = 1 and rdata = 0xDEADBEEF.
- Store with 3 wait cycles: mem_write = 1, addr = 0x204, wdata = 0x12345678, bus_ack 3 cycles late. Expect bus_we = 1 and bus_wdata stable during REQ, stall high for 5 cycles, and no rdata_valid.
- Misaligned access: mem_read = 1, addr = 0x102. Expect misalign_err = 1, stall = 0, and bus_req never asserted.
- Reset mid-transaction: assert rst while in REQ. Expect bus_req to drop without waiting for a clk edge, state = IDLE, and all outputs at reset values. A following load of 0x0 completes normally.
- Back-to-back loads to 0x0 then 0x4, with bus_rdata 0x11 then 0x22. Expect two separate bus_req pulses and rdata_valid pulses carrying 0x11 then 0x22.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4: load with no ack. Expect bus_req to drop after 4 REQ cycles, timeout_err = 1 for 1 cycle, rdata_valid = 0, and stall released.

Source files
------------

// File: rtl/dmem_access_unit.sv
// Data-memory access sequencer: turns a MEM-stage load/store into one req/ack bus
// transaction and stalls the pipeline until it completes. Optional abort: MEM_TIMEOUT_EN.
module dmem_access_unit #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              misalign_err,
    output logic              timeout_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t state, state_nx;
    logic   acc, aligned, start, to_abort, timed_out;

    assign acc     = mem_read | mem_write;
    assign aligned = (addr[1:0] == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        start        = 1'b0;
        stall        = 1'b0;
        misalign_err = 1'b0;
        bus_req      = 1'b0;
        rdata_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (acc) begin
                    if (aligned) begin
                        start    = 1'b1;
                        stall    = 1'b1;
                        state_nx = REQ;
                    end else begin
                        misalign_err = 1'b1;
                    end
                end
            end
            REQ: begin
                bus_req = 1'b1;
                stall   = 1'b1;
                // ack wins over an expiring timeout in the same cycle
                if (bus_ack || to_abort) state_nx = RESP;
            end
            RESP: begin
                rdata_valid = ~bus_we & ~timed_out;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // the pipeline must not see a stall or error while held in reset
        if (rst) begin
            stall        = 1'b0;
            misalign_err = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_we    <= 1'b0;
            rdata     <= '0;
        end else begin
            if (start) begin
                bus_addr  <= addr;
                bus_wdata <= wdata;
                bus_we    <= mem_write;
            end
            if (state == REQ && bus_ack && !bus_we) rdata <= bus_rdata;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          to_flag;

    assign to_abort    = (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign timed_out   = to_flag;
    assign timeout_err = (state == RESP) & to_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            to_flag <= 1'b0;
        end else if (start) begin
            cnt     <= '0;
            to_flag <= 1'b0;
        end else if (state == REQ) begin
            cnt     <= cnt + CW'(1);
            to_flag <= to_abort & ~bus_ack;
        end
    end
`else
    assign to_abort    = 1'b0;
    assign timed_out   = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed plan cases plus randomized
// accesses checked against a transaction-level expectation model.
module tb_dmem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        stall, rdata_valid, misalign_err, timeout_err;
    logic [31:0] rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int          n_checks = 0, n_pass = 0;
    logic [31:0] exp_rdata = '0;   // data of the most recently completed load

    dmem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
        .rdata_valid(rdata_valid), .misalign_err(misalign_err), .timeout_err(timeout_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // One complete access; the bus acks after 'waits' idle REQ cycles.
    task automatic access(input logic we, input logic re, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int waits);
        int n_stall, n_req;
        n_stall = 0; n_req = 0;
        @(negedge clk);
        mem_read = re; mem_write = we; addr = a; wdata = wd; bus_ack = 1'b0;
        #1;
        n_stall += int'(stall);
        n_checks++;
        if ({stall, bus_req, misalign_err, rdata_valid} !== 4'b1000)
            $display("FAIL access_start got %b want 1000", {stall, bus_req, misalign_err, rdata_valid});
        else n_pass++;
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            mem_read = 1'($urandom); mem_write = 1'($urandom); addr = $urandom; wdata = $urandom;
            bus_ack = (i == waits);
            bus_rdata = (i == waits) ? rd : $urandom;
            #1;
            n_stall += int'(stall); n_req += int'(bus_req);
            n_checks++;
            if ({bus_req, stall, bus_we, timeout_err} !== {2'b11, we, 1'b0})
                $display("FAIL req_ctrl got %b want %b", {bus_req, stall, bus_we, timeout_err}, {2'b11, we, 1'b0});
            else n_pass++;
            n_checks++;
            if (bus_addr !== a || bus_wdata !== wd)
                $display("FAIL req_hold got %h/%h want %h/%h", bus_addr, bus_wdata, a, wd);
            else n_pass++;
        end
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
        if (!we) exp_rdata = rd;
        #1;
        n_stall += int'(stall); n_req += int'(bus_req);
        n_checks++;
        if ({stall, bus_req, rdata_valid, timeout_err} !== {2'b00, ~we, 1'b0})
            $display("FAIL resp_ctrl got %b want %b", {stall, bus_req, rdata_valid, timeout_err}, {2'b00, ~we, 1'b0});
        else n_pass++;
        n_checks++;
        if (rdata !== exp_rdata) $display("FAIL resp_rdata got %h want %h", rdata, exp_rdata);
        else n_pass++;
        n_checks++;
        if (n_stall != waits + 2 || n_req != waits + 1)
            $display("FAIL cycle_count stall %0d req %0d want %0d %0d", n_stall, n_req, waits + 2, waits + 1);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_read = 1'b1; addr = 32'h40;
        #12;
        n_checks++;
        if ({stall, bus_req, bus_we, rdata_valid, misalign_err, timeout_err} !== 6'b0)
            $display("FAIL reset_ctrl got %b want 000000", {stall, bus_req, bus_we, rdata_valid, misalign_err, timeout_err});
        else n_pass++;
        n_checks++;
        if (bus_addr !== 0 || bus_wdata !== 0 || rdata !== 0)
            $display("FAIL reset_data got %h %h %h want 0 0 0", bus_addr, bus_wdata, rdata);
        else n_pass++;
        addr = 32'h41;
        #1;
        n_checks++;
        if (misalign_err !== 1'b0) $display("FAIL reset_misalign got %b want 0", misalign_err);
        else n_pass++;
        @(negedge clk);
        mem_read = 1'b0; addr = '0; rst = 1'b0;
    endtask

    task automatic test_misalign(input logic [31:0] a, input logic re);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_read = re; mem_write = ~re; addr = a;
            #1;
            n_checks++;
            if ({misalign_err, stall, bus_req} !== 3'b100)
                $display("FAIL misalign got %b want 100", {misalign_err, stall, bus_req});
            else n_pass++;
        end
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0; addr = '0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mem_read = 1'b1; addr = 32'h80;
        @(negedge clk);
        mem_read = 1'b0;
        #1;
        n_checks++;
        if (bus_req !== 1'b1) $display("FAIL rstmid_inreq got %b want 1", bus_req);
        else n_pass++;
        #1 rst = 1'b1;
        #1;
        exp_rdata = '0;
        n_checks++;
        if ({bus_req, stall, rdata_valid, bus_we} !== 4'b0)
            $display("FAIL rstmid_async got %b want 0000", {bus_req, stall, rdata_valid, bus_we});
        else n_pass++;
        n_checks++;
        if (rdata !== 0 || bus_addr !== 0 || bus_wdata !== 0)
            $display("FAIL rstmid_data got %h %h %h want 0 0 0", rdata, bus_addr, bus_wdata);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus_req, rdata_valid} !== 2'b00)
            $display("FAIL rstmid_after got %b want 00", {bus_req, rdata_valid});
        else n_pass++;
        access(1'b0, 1'b1, 32'h0, 32'h0, 32'h5A5A_0F0F, 0);
    endtask

    task automatic test_back_to_back();
        access(1'b0, 1'b1, 32'h0, 32'h0, 32'h11, 0);
        access(1'b0, 1'b1, 32'h4, 32'h0, 32'h22, 0);
        @(negedge clk);
        #1;
        n_checks++;
        if (rdata !== 32'h22 || rdata_valid !== 1'b0)
            $display("FAIL b2b_hold got %h/%b want 00000022/0", rdata, rdata_valid);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            int kind;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            a = $urandom;
            if (kind == 3) begin
                if (a[1:0] == 2'b00) a[0] = 1'b1;
                test_misalign(a, 1'($urandom));
            end else begin
                a[1:0] = 2'b00;
                // kind 2 raises both strobes: the write must win
                access(kind != 0, kind != 1, a, $urandom, $urandom, $urandom_range(0, TO - 1));
            end
        end
    endtask

    task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
        logic [31:0] held;
        held = exp_rdata;
        @(negedge clk);
        mem_read = 1'b1; addr = 32'h300; bus_ack = 1'b0;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            mem_read = 1'b0;
            #1;
            n_checks++;
            if ({bus_req, stall} !== 2'b11) $display("FAIL to_req got %b want 11", {bus_req, stall});
            else n_pass++;
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus_req, stall, rdata_valid, timeout_err} !== 4'b0001)
            $display("FAIL to_abort got %b want 0001", {bus_req, stall, rdata_valid, timeout_err});
        else n_pass++;
        n_checks++;
        if (rdata !== held) $display("FAIL to_rdata got %h want %h", rdata, held);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if ({timeout_err, bus_req} !== 2'b00) $display("FAIL to_pulse got %b want 00", {timeout_err, bus_req});
        else n_pass++;
`else
        // without the abort path a long wait must simply complete
        access(1'b0, 1'b1, 32'h300, 32'h0, 32'hCAFE_F00D, 3 * TO);
`endif
    endtask

    initial begin
        test_reset();
        access(1'b0, 1'b1, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
        access(1'b1, 1'b0, 32'h204, 32'h1234_5678, 32'h0, 3);
        test_misalign(32'h102, 1'b1);
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        test_random();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
